// File: rtl/raccoon_motion_ctrl.sv
// raccoon_motion_ctrl: debounced push-button control of the raccoon sprite
// position. The position is updated once every MOVE_DIV frames, right after
// the falling edge of vga_vs, so the display never shows a torn sprite.
module raccoon_motion_ctrl #(
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int SPRITE_SIZE     = 32,
  parameter int STEP            = 4,
  parameter int MOVE_DIV        = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int START_X         = 304,
  parameter int START_Y         = 224
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       vga_vs,
  output logic [9:0] raccoon_x,
  output logic [9:0] raccoon_y,
  output logic       moving,
  output logic       frame_tick
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);

  localparam logic signed [10:0] MAX_X = 11'(SCREEN_W - SPRITE_SIZE);
  localparam logic signed [10:0] MAX_Y = 11'(SCREEN_H - SPRITE_SIZE);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    UPDATE_X,
    UPDATE_Y
  } state_t;

  // Button bit order everywhere: [3]=up, [2]=down, [1]=left, [0]=right
  logic [3:0]      btn_raw;
  logic [3:0]      btn_s1_q;
  logic [3:0]      btn_s2_q;
  logic [3:0]      btn_db_q;
  logic [DB_W-1:0] db_cnt_q [4];

  logic             vs_s1_q;
  logic             vs_s2_q;
  logic             vs_prev_q;
  logic             frame_tick_q;
  logic [DIV_W-1:0] div_q;
  logic             upd_sched;

  state_t     state_q;
  logic [3:0] dir_q;
  logic [9:0] x_q;
  logic [9:0] y_q;
  logic [9:0] x_d;
  logic [9:0] y_d;
  logic       x_chg_q;
  logic       moving_q;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  // Saturating one-axis move in 11-bit signed arithmetic; opposing or no
  // buttons leave the position unchanged.
  function automatic logic [9:0] step_axis(
    input logic [9:0]         pos,
    input logic               dec,
    input logic               inc,
    input logic signed [10:0] max
  );
    logic signed [10:0] p;
    logic signed [10:0] s;
    logic signed [10:0] r;
    p = {1'b0, pos};
    s = 11'(STEP);
    if (dec && !inc) begin
      r = p - s;
    end else if (inc && !dec) begin
      r = p + s;
    end else begin
      r = p;
    end
    if (r < 0) begin
      r = '0;
    end else if (r > max) begin
      r = max;
    end
    return r[9:0];
  endfunction

  // Two-flop synchronizers for the raw buttons and vga_vs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      vs_s1_q  <= 1'b1;
      vs_s2_q  <= 1'b1;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      vs_s1_q  <= vga_vs;
      vs_s2_q  <= vs_s1_q;
    end
  end

  // Per-button debounce: accept a new level only after it held DEBOUNCE_CYCLES
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_db_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (btn_s2_q[i] != btn_db_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            btn_db_q[i] <= btn_s2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Frame start detect on falling synced vga_vs, and frame divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev_q    <= 1'b1;
      frame_tick_q <= 1'b0;
      div_q        <= '0;
    end else begin
      vs_prev_q    <= vs_s2_q;
      frame_tick_q <= vs_prev_q & ~vs_s2_q;
      if (frame_tick_q) begin
        div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end
    end
  end

  // Ticks arriving outside IDLE still advance the divider but are dropped here
  assign upd_sched = frame_tick_q && (div_q == DIV_LAST);

  // Candidate next positions from the latched direction
  always_comb begin
    x_d = step_axis(x_q, dir_q[1], dir_q[0], MAX_X);
    y_d = step_axis(y_q, dir_q[3], dir_q[2], MAX_Y);
  end

  // Update sequencer: sample buttons, then X, then Y; moving follows Y
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      dir_q    <= '0;
      x_q      <= 10'(START_X);
      y_q      <= 10'(START_Y);
      x_chg_q  <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      moving_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (upd_sched) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          dir_q   <= btn_db_q;
          state_q <= UPDATE_X;
        end
        UPDATE_X: begin
          x_q     <= x_d;
          x_chg_q <= (x_d != x_q);
          state_q <= UPDATE_Y;
        end
        UPDATE_Y: begin
          y_q      <= y_d;
          moving_q <= x_chg_q | (y_d != y_q);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign raccoon_x  = x_q;
  assign raccoon_y  = y_q;
  assign moving     = moving_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_raccoon_motion_ctrl.sv
// Scoreboard bench for raccoon_motion_ctrl: the stimulus pushes the expected
// position/moving result of every frame; a monitor pops on each frame_tick.
module tb_raccoon_motion_ctrl;

  localparam int DB    = 16;
  localparam int MD    = 2;
  localparam int MAXX  = 608;
  localparam int MAXY  = 448;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       vga_vs;
  logic [9:0] raccoon_x, raccoon_y;
  logic       moving, frame_tick;

  typedef struct {
    int x;
    int y;
    int mv;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int exp_x, exp_y, tb_div;
  bit m_u, m_d, m_l, m_r;

  raccoon_motion_ctrl #(
    .MOVE_DIV       (MD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .vga_vs    (vga_vs),
    .raccoon_x (raccoon_x),
    .raccoon_y (raccoon_y),
    .moving    (moving),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int mstep(input int p, input bit dec, input bit inc, input int mx);
    int r;
    r = p;
    if (dec && !inc) r = p - 4;
    else if (inc && !dec) r = p + 4;
    if (r < 0) r = 0;
    if (r > mx) r = mx;
    return r;
  endfunction

  // One 64-cycle frame: vs low 4 cycles, high 60; expectation pushed at the fall
  task automatic frame(input bit f_up);
    bit sched;
    int nx, ny, mv;
    @(posedge clk);
    #1 vga_vs = 1'b0;
    sched  = (tb_div == MD - 1);
    tb_div = sched ? 0 : tb_div + 1;
    mv = 0;
    if (sched) begin
      nx = mstep(exp_x, m_l, m_r, MAXX);
      ny = mstep(exp_y, m_u | f_up, m_d, MAXY);
      mv = ((nx != exp_x) || (ny != exp_y)) ? 1 : 0;
      exp_x = nx;
      exp_y = ny;
    end
    sb.push_back('{exp_x, exp_y, mv});
    repeat (4) @(posedge clk);
    #1 vga_vs = 1'b1;
    repeat (59) @(posedge clk);
  endtask

  // Change button pins, wait for debounce to settle, then update the model
  task automatic set_btns(input bit u, input bit d, input bit l, input bit r);
    @(posedge clk);
    #1;
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    repeat (DB + 14) @(posedge clk);
    m_u = u; m_d = d; m_l = l; m_r = r;
  endtask

  task automatic glitch(input int off, input int len);
    repeat (off) @(posedge clk);
    #1 btn_up = 1'b1;
    repeat (len) @(posedge clk);
    #1 btn_up = 1'b0;
  endtask

  // Monitor: on every frame_tick pop one expectation and check the outcome
  initial begin
    exp_t e;
    int   pulses;
    forever begin
      @(negedge clk);
      if (frame_tick === 1'b1) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame_tick: got tick, expected none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          pulses = 0;
          repeat (8) begin
            @(negedge clk);
            if (moving === 1'b1) pulses++;
          end
          chk("frame_x", int'(raccoon_x), e.x);
          chk("frame_y", int'(raccoon_y), e.y);
          chk("frame_moving_pulses", pulses, e.mv);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #5ms;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    bit got;
    int y_hold;
    reset = 1'b1;
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    vga_vs = 1'b1;
    exp_x = 304; exp_y = 224; tb_div = 0;
    m_u = 0; m_d = 0; m_l = 0; m_r = 0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_x", int'(raccoon_x), 304);
    chk("reset_y", int'(raccoon_y), 224);
    chk("reset_moving", int'(moving), 0);
    chk("reset_frame_tick", int'(frame_tick), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Idle: no buttons, ten frames
    repeat (10) frame(0);
    chk("idle_x", int'(raccoon_x), 304);
    chk("idle_y", int'(raccoon_y), 224);

    // Right held for 4 scheduled updates
    set_btns(0, 0, 0, 1);
    repeat (8) frame(0);
    chk("right_x", int'(raccoon_x), 320);
    chk("right_y", int'(raccoon_y), 224);

    // Reset asserted while the FSM is in UPDATE_X of a scheduled update
    while (tb_div != MD - 1) frame(0);
    sb.push_back('{304, 224, 0});
    tb_div = 0;
    exp_x = 304;
    exp_y = 224;
    @(posedge clk);
    #1 vga_vs = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) got = 1;
    end
    chk("rst_mid_tick_seen", int'(got), 1);
    @(posedge clk);
    #1 vga_vs = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rst_mid_x_immediate", int'(raccoon_x), 304);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (56) @(posedge clk);
    frame(0);
    chk("rst_mid_first_tick_no_move", int'(raccoon_x), 304);
    frame(0);
    chk("rst_mid_second_tick_move", int'(raccoon_x), 308);

    // Opposite left+right with up
    set_btns(1, 0, 1, 1);
    repeat (4) frame(0);
    chk("opposite_x", int'(raccoon_x), 308);
    chk("opposite_y", int'(raccoon_y), 216);

    // Left clamp at 0
    set_btns(0, 0, 1, 0);
    repeat (160) frame(0);
    chk("left_clamp_x", int'(raccoon_x), 0);

    // Down clamp at 448
    set_btns(0, 1, 0, 0);
    repeat (130) frame(0);
    chk("down_clamp_y", int'(raccoon_y), 448);

    // Short glitches on btn_up around frame edges are never accepted
    set_btns(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      fork
        frame(0);
        glitch((i * 7) % 50, DB - 2);
      join
    end
    chk("glitch_y", int'(raccoon_y), 448);

    // A press held DB+10 cycles is accepted at the next scheduled update
    while (tb_div != 0) frame(0);
    y_hold = int'(raccoon_y);
    fork
      begin
        repeat (44) @(posedge clk);
        #1 btn_up = 1'b1;
        repeat (DB + 10) @(posedge clk);
        #1 btn_up = 1'b0;
      end
    join_none
    frame(0);
    frame(1);
    chk("press_y", int'(raccoon_y), y_hold - 4);
    repeat (2) frame(0);
    chk("press_released_y", int'(raccoon_y), y_hold - 4);

    repeat (20) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
